// File: rtl/mem_stage_if.sv
// Port bundle for mem_stage: ALU-stage inputs, data-memory port and writeback outputs.
// "slave" is the stage's own view; "master" is the view of the surrounding pipeline/memory.
interface mem_stage_if #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 32,
   parameter int REGISTER_WIDTH = 5
);
   logic                      valid_i;
   logic                      reg_wr_en_i;
   logic                      is_load_i;
   logic                      is_store_i;
   logic [DATA_WIDTH-1:0]     alu_result_i;
   logic [DATA_WIDTH-1:0]     reg_a_data_i;
   logic [REGISTER_WIDTH-1:0] wr_reg_i;
   logic                      stall_o;
   logic                      dmem_req_o;
   logic                      dmem_we_o;
   logic [ADDR_WIDTH-1:0]     dmem_addr_o;
   logic [DATA_WIDTH-1:0]     dmem_wdata_o;
   logic                      dmem_ready_i;
   logic [DATA_WIDTH-1:0]     dmem_rdata_i;
   logic                      wb_valid_o;
   logic                      wb_reg_wr_en_o;
   logic [REGISTER_WIDTH-1:0] wb_wr_reg_o;
   logic [DATA_WIDTH-1:0]     wb_data_o;
   logic                      wb_misaligned_o;

   modport slave (
      input  valid_i, reg_wr_en_i, is_load_i, is_store_i, alu_result_i, reg_a_data_i, wr_reg_i,
             dmem_ready_i, dmem_rdata_i,
      output stall_o, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
             wb_valid_o, wb_reg_wr_en_o, wb_wr_reg_o, wb_data_o, wb_misaligned_o
   );

   modport master (
      output valid_i, reg_wr_en_i, is_load_i, is_store_i, alu_result_i, reg_a_data_i, wr_reg_i,
             dmem_ready_i, dmem_rdata_i,
      input  stall_o, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
             wb_valid_o, wb_reg_wr_en_o, wb_wr_reg_o, wb_data_o, wb_misaligned_o
   );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: passes ALU results through, issues word loads/stores to a
// variable-latency data memory, stalls upstream while an access is outstanding.
module mem_stage #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 32,
   parameter int REGISTER_WIDTH = 5
) (
   input  logic        clk_i,
   input  logic        rst_i,
   mem_stage_if.slave  bus
);
   typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

   typedef struct packed {
      logic                      we;
      logic                      reg_wr_en;
      logic [REGISTER_WIDTH-1:0] wr_reg;
      logic [ADDR_WIDTH-1:0]     addr;
      logic [DATA_WIDTH-1:0]     wdata;
   } req_t;

   state_t                    r_state, w_state_nxt;
   req_t                      r_req, w_req_nxt;
   logic                      r_wb_valid, w_wb_valid_nxt;
   logic                      r_wb_en, w_wb_en_nxt;
   logic [REGISTER_WIDTH-1:0] r_wb_reg, w_wb_reg_nxt;
   logic [DATA_WIDTH-1:0]     r_wb_data, w_wb_data_nxt;
   logic                      r_wb_mis, w_wb_mis_nxt;

   logic w_is_mem, w_misal, w_access;

   assign w_is_mem = bus.is_load_i | bus.is_store_i;
   assign w_misal  = |bus.alu_result_i[1:0];
   assign w_access = (r_state == ACCESS);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state    <= IDLE;
         r_req      <= '0;
         r_wb_valid <= 1'b0;
         r_wb_en    <= 1'b0;
         r_wb_reg   <= '0;
         r_wb_data  <= '0;
         r_wb_mis   <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_req      <= w_req_nxt;
         r_wb_valid <= w_wb_valid_nxt;
         r_wb_en    <= w_wb_en_nxt;
         r_wb_reg   <= w_wb_reg_nxt;
         r_wb_data  <= w_wb_data_nxt;
         r_wb_mis   <= w_wb_mis_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_req_nxt      = r_req;
      w_wb_valid_nxt = 1'b0;
      w_wb_en_nxt    = r_wb_en;
      w_wb_reg_nxt   = r_wb_reg;
      w_wb_data_nxt  = r_wb_data;
      w_wb_mis_nxt   = r_wb_mis;
      case (r_state)
         IDLE: begin
            if (bus.valid_i) begin
               if (w_is_mem && !w_misal) begin
                  // LW+SW together resolves to a store since we follows is_store_i
                  w_req_nxt.we        = bus.is_store_i;
                  w_req_nxt.reg_wr_en = bus.reg_wr_en_i;
                  w_req_nxt.wr_reg    = bus.wr_reg_i;
                  w_req_nxt.addr      = bus.alu_result_i[ADDR_WIDTH-1:0];
                  w_req_nxt.wdata     = bus.reg_a_data_i;
                  w_state_nxt         = ACCESS;
               end else begin
                  w_wb_valid_nxt = 1'b1;
                  w_wb_en_nxt    = bus.reg_wr_en_i & ~w_is_mem;
                  w_wb_reg_nxt   = bus.wr_reg_i;
                  w_wb_data_nxt  = bus.alu_result_i;
                  w_wb_mis_nxt   = w_is_mem;
               end
            end
         end
         ACCESS: begin
            if (bus.dmem_ready_i) begin
               w_state_nxt    = IDLE;
               w_wb_valid_nxt = 1'b1;
               w_wb_mis_nxt   = 1'b0;
               w_wb_reg_nxt   = r_req.wr_reg;
               if (r_req.we) begin
                  w_wb_en_nxt   = 1'b0;
                  w_wb_data_nxt = DATA_WIDTH'(r_req.addr);
               end else begin
                  w_wb_en_nxt   = r_req.reg_wr_en;
                  w_wb_data_nxt = bus.dmem_rdata_i;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Memory-side outputs decode only registered state, so reset drops them asynchronously.
   assign bus.stall_o         = w_access;
   assign bus.dmem_req_o      = w_access;
   assign bus.dmem_we_o       = w_access & r_req.we;
   assign bus.dmem_addr_o     = w_access ? r_req.addr  : '0;
   assign bus.dmem_wdata_o    = w_access ? r_req.wdata : '0;
   assign bus.wb_valid_o      = r_wb_valid;
   assign bus.wb_reg_wr_en_o  = r_wb_en;
   assign bus.wb_wr_reg_o     = r_wb_reg;
   assign bus.wb_data_o       = r_wb_data;
   assign bus.wb_misaligned_o = r_wb_mis;
endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases plus randomized instructions and memory
// latencies, checked against an instruction-level reference of the writeback/memory results.
module tb_mem_stage;
   localparam int DW = 32;
   localparam int AW = 32;
   localparam int RW = 5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_stage_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REGISTER_WIDTH(RW)) bus ();

   mem_stage #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REGISTER_WIDTH(RW)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_err = 0;

   // last writeback entry the reference expects to be held on the wb_* outputs
   logic          m_en;
   logic [RW-1:0] m_reg;
   logic [DW-1:0] m_data;
   logic          m_mis;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic chk_wb(input string tag, input logic vld);
      chk({tag, ".wb_valid"}, bus.wb_valid_o, vld);
      chk({tag, ".wb_en"},    bus.wb_reg_wr_en_o, m_en);
      chk({tag, ".wb_reg"},   bus.wb_wr_reg_o, m_reg);
      chk({tag, ".wb_data"},  bus.wb_data_o, m_data);
      chk({tag, ".wb_mis"},   bus.wb_misaligned_o, m_mis);
   endtask

   task automatic drive_junk();
      bus.valid_i      = 1'($urandom);
      bus.reg_wr_en_i  = 1'($urandom);
      bus.is_load_i    = 1'($urandom);
      bus.is_store_i   = 1'($urandom);
      bus.alu_result_i = $urandom;
      bus.reg_a_data_i = $urandom;
      bus.wr_reg_i     = RW'($urandom);
   endtask

   // One instruction: present at a negedge, accepted at the next posedge (edge T). Memory ops
   // see ready after k further request cycles; rd is the load data returned at completion.
   task automatic do_instr(input string tag, input logic v, input logic wen, input logic ld,
                           input logic st, input logic [DW-1:0] alu, input logic [DW-1:0] a,
                           input logic [RW-1:0] wr, input int k, input logic [DW-1:0] rd,
                           input bit junk);
      bit mem, mis;
      @(negedge clk);
      bus.valid_i      = v;
      bus.reg_wr_en_i  = wen;
      bus.is_load_i    = ld;
      bus.is_store_i   = st;
      bus.alu_result_i = alu;
      bus.reg_a_data_i = a;
      bus.wr_reg_i     = wr;
      bus.dmem_ready_i = 1'($urandom);   // stray ready while idle must be ignored
      bus.dmem_rdata_i = $urandom;
      chk({tag, ".pre_stall"}, bus.stall_o, 1'b0);
      mem = ld | st;
      mis = (alu % 4) != 0;
      @(posedge clk); #1;
      if (!v) begin
         chk_wb(tag, 1'b0);
         chk({tag, ".req"}, bus.dmem_req_o, 1'b0);
      end else if (!mem || mis) begin
         m_en = mem ? 1'b0 : wen; m_reg = wr; m_data = alu; m_mis = mem;
         chk_wb(tag, 1'b1);
         chk({tag, ".req"}, bus.dmem_req_o, 1'b0);
         chk({tag, ".stall"}, bus.stall_o, 1'b0);
      end else begin
         for (int j = 0; j <= k; j++) begin
            chk({tag, ".acc_req"},   bus.dmem_req_o, 1'b1);
            chk({tag, ".acc_stall"}, bus.stall_o, 1'b1);
            chk({tag, ".acc_we"},    bus.dmem_we_o, st);
            chk({tag, ".acc_addr"},  bus.dmem_addr_o, alu);
            chk({tag, ".acc_wdata"}, bus.dmem_wdata_o, a);
            chk({tag, ".acc_wbv"},   bus.wb_valid_o, 1'b0);
            @(negedge clk);
            if (junk) drive_junk();
            bus.dmem_ready_i = (j == k);
            bus.dmem_rdata_i = (j == k) ? rd : $urandom;
            @(posedge clk); #1;
         end
         m_en = st ? 1'b0 : wen; m_reg = wr; m_data = st ? alu : rd; m_mis = 1'b0;
         chk_wb(tag, 1'b1);
         chk({tag, ".done_req"},   bus.dmem_req_o, 1'b0);
         chk({tag, ".done_stall"}, bus.stall_o, 1'b0);
      end
   endtask

   initial begin
      bus.valid_i = 0; bus.reg_wr_en_i = 0; bus.is_load_i = 0; bus.is_store_i = 0;
      bus.alu_result_i = 0; bus.reg_a_data_i = 0; bus.wr_reg_i = 0;
      bus.dmem_ready_i = 0; bus.dmem_rdata_i = 0;
      m_en = 0; m_reg = 0; m_data = 0; m_mis = 0;
      repeat (2) @(posedge clk);
      #1;
      chk_wb("reset", 1'b0);
      chk("reset.req",   bus.dmem_req_o, 1'b0);
      chk("reset.stall", bus.stall_o, 1'b0);
      chk("reset.addr",  bus.dmem_addr_o, 0);
      @(negedge clk); rst = 1'b0;

      do_instr("alu",   1, 1, 0, 0, 32'h0000_002A, 32'h0, 5'd7, 0, 32'h0, 0);
      do_instr("lw",    1, 1, 1, 0, 32'h0000_0100, 32'h0, 5'd3, 2, 32'hDEAD_BEEF, 0);
      do_instr("idle",  0, 1, 1, 0, 32'h0000_0200, 32'h0, 5'd9, 0, 32'h0, 0);
      do_instr("sw",    1, 1, 0, 1, 32'h0000_0040, 32'h1234_5678, 5'd4, 0, 32'h0, 0);
      do_instr("misal", 1, 1, 1, 0, 32'h0000_0102, 32'h0, 5'd5, 0, 32'h0, 0);
      do_instr("lwsw",  1, 1, 1, 1, 32'h0000_0080, 32'hCAFE_F00D, 5'd6, 1, 32'h5555_5555, 1);
      // load then an ALU op straight after: its writeback lands on the very next cycle
      do_instr("hold_lw",  1, 1, 1, 0, 32'h0000_0300, 32'h0, 5'd8, 0, 32'hA5A5_0001, 0);
      do_instr("hold_alu", 1, 1, 0, 0, 32'h0000_0077, 32'h0, 5'd9, 0, 32'h0, 0);

      for (int i = 0; i < 300; i++) begin
         logic [DW-1:0] alu;
         alu = $urandom;
         if ($urandom_range(0, 3) != 0) alu = alu & ~32'h3;
         do_instr("rnd", ($urandom_range(0, 4) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
                  alu, $urandom, RW'($urandom), $urandom_range(0, 4), $urandom, 1'($urandom));
      end

      // asynchronous reset in the middle of an access abandons it
      @(negedge clk);
      bus.valid_i = 1; bus.reg_wr_en_i = 1; bus.is_load_i = 1; bus.is_store_i = 0;
      bus.alu_result_i = 32'h0000_0400; bus.wr_reg_i = 5'd2; bus.dmem_ready_i = 0;
      @(posedge clk); #1;
      chk("rst_mid.req_before", bus.dmem_req_o, 1'b1);
      #2 rst = 1'b1;
      #1;
      m_en = 0; m_reg = 0; m_data = 0; m_mis = 0;
      chk("rst_mid.req",   bus.dmem_req_o, 1'b0);
      chk("rst_mid.stall", bus.stall_o, 1'b0);
      chk_wb("rst_mid", 1'b0);
      @(negedge clk);
      rst = 1'b0; bus.valid_i = 0; bus.dmem_ready_i = 1; bus.dmem_rdata_i = 32'hFFFF_FFFF;
      repeat (2) begin
         @(posedge clk); #1;
         chk_wb("rst_after", 1'b0);
         chk("rst_after.req", bus.dmem_req_o, 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
